// File: rtl/wasm_call_ctrl_if.sv
//------------------------------------------------------------------------------
// wasm_call_pkg / wasm_call_ctrl_if
//   Shared types for the call/return sequencer, and the bundle of its
//   handshake and bus signals.
//   Types:
//     frame_entry_t : one call-stack frame {return_pc, locals_base,
//                     stack_base, func_idx}
//     trap_t        : trap code returned to execute (TRAP_NONE = no trap)
//   Interface signals (direction as seen by the sequencer, modport slave):
//     req_*    in  : request from decode/execute (valid/ready handshake)
//     ft_rd_*  out : function-table read, ft_* data returns one cycle later
//     cs_*          : call-stack push/pop control and status
//     done_*   out : result to execute (valid/ready handshake)
//   Modport master is the environment view (opposite directions).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wasm_call_pkg;
  localparam int FRAME_SP_W = 16;

  typedef struct packed {
    logic [31:0]           return_pc;
    logic [FRAME_SP_W-1:0] locals_base;
    logic [FRAME_SP_W-1:0] stack_base;
    logic [15:0]           func_idx;
  } frame_entry_t;

  typedef enum logic [2:0] {
    TRAP_NONE                 = 3'd0,
    TRAP_UNREACHABLE          = 3'd1,
    TRAP_UNDEFINED_ELEMENT    = 3'd2,
    TRAP_STACK_UNDERFLOW      = 3'd3,
    TRAP_STACK_OVERFLOW       = 3'd4,
    TRAP_CALL_STACK_EXHAUSTED = 3'd5
  } trap_t;

  localparam logic [1:0] OP_CALL   = 2'd0;
  localparam logic [1:0] OP_RETURN = 2'd1;
  localparam logic [1:0] OP_TAIL   = 2'd2;
endpackage

interface wasm_call_ctrl_if #(
  parameter int SP_W = 16
);
  import wasm_call_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [15:0]     req_func_idx;
  logic [31:0]     req_return_pc;
  logic [SP_W-1:0] req_locals_base;
  logic [SP_W-1:0] req_sp;
  logic [7:0]      req_result_count;

  logic            ft_rd_en;
  logic [15:0]     ft_rd_addr;
  logic [31:0]     ft_entry_pc;
  logic [7:0]      ft_num_params;
  logic [15:0]     ft_num_locals;

  logic            cs_push_en;
  logic            cs_pop_en;
  frame_entry_t    cs_push_data;
  frame_entry_t    cs_pop_data;
  logic            cs_full;
  logic            cs_empty;

  logic            done_valid;
  logic            done_ready;
  logic [31:0]     done_pc;
  logic [SP_W-1:0] done_locals_base;
  logic [SP_W-1:0] done_sp;
  logic            done_exit;
  trap_t           done_trap;

  modport slave (
    input  req_valid, req_op, req_func_idx, req_return_pc, req_locals_base,
           req_sp, req_result_count,
    output req_ready,
    output ft_rd_en, ft_rd_addr,
    input  ft_entry_pc, ft_num_params, ft_num_locals,
    output cs_push_en, cs_pop_en, cs_push_data,
    input  cs_pop_data, cs_full, cs_empty,
    output done_valid, done_pc, done_locals_base, done_sp, done_exit, done_trap,
    input  done_ready
  );

  modport master (
    output req_valid, req_op, req_func_idx, req_return_pc, req_locals_base,
           req_sp, req_result_count,
    input  req_ready,
    input  ft_rd_en, ft_rd_addr,
    output ft_entry_pc, ft_num_params, ft_num_locals,
    input  cs_push_en, cs_pop_en, cs_push_data,
    output cs_pop_data, cs_full, cs_empty,
    input  done_valid, done_pc, done_locals_base, done_sp, done_exit, done_trap,
    output done_ready
  );
endinterface

`default_nettype wire

// File: rtl/wasm_call_ctrl.sv
//------------------------------------------------------------------------------
// wasm_call_ctrl
//   Call/return sequencer in front of the call stack. Accepts CALL, RETURN
//   and (optionally) TAIL_CALL requests, reads the callee's function-table
//   entry, pushes/pops call-stack frames and reports new PC / locals base /
//   operand SP, program exit, or a trap.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : wasm_call_ctrl_if.slave (request, function table, call stack,
//            result handshakes)
//   Parameters:
//     FUNC_COUNT : number of valid function-table entries
//     SP_W       : operand stack pointer / locals base width (must match
//                  the interface and wasm_call_pkg::FRAME_SP_W)
//   Optional feature macro: WASM_CALL_TAIL_EN enables TAIL_CALL (op 2);
//   without it op 2 traps as unreachable.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wasm_call_ctrl
  import wasm_call_pkg::*;
#(
  parameter int FUNC_COUNT = 256,
  parameter int SP_W       = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wasm_call_ctrl_if.slave    bus
);

`ifdef WASM_CALL_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_POP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [15:0]     func_idx_q;
  logic [31:0]     ret_pc_q;
  logic [SP_W-1:0] locals_base_q;
  logic [SP_W-1:0] sp_q;
  logic [7:0]      result_count_q;

  logic            ft_rd_en_q;
  logic [15:0]     ft_rd_addr_q;
  logic            done_valid_q;
  logic [31:0]     done_pc_q;
  logic [SP_W-1:0] done_lb_q;
  logic [SP_W-1:0] done_sp_q;
  logic            done_exit_q;
  trap_t           done_trap_q;

  // Frame-arithmetic is done one bit wider so the top bit flags
  // borrow (nb) or carry (nsp).
  logic [SP_W:0]   nb_d;
  logic [SP_W:0]   nsp_d;
  trap_t           chk_trap_d;
  logic            is_tail_d;
  logic            push_d;
  logic            pop_d;
  frame_entry_t    push_data_d;
  logic [SP_W-1:0] ret_sp_d;
  logic            w_unused_bits;

  always_comb begin
    nb_d      = {1'b0, sp_q} - (SP_W+1)'(bus.ft_num_params);
    nsp_d     = nb_d + (SP_W+1)'(bus.ft_num_params) + (SP_W+1)'(bus.ft_num_locals);
    is_tail_d = TAIL_EN && (op_q == OP_TAIL);

    if (nb_d[SP_W])
      chk_trap_d = TRAP_STACK_UNDERFLOW;
    else if (nsp_d[SP_W])
      chk_trap_d = TRAP_STACK_OVERFLOW;
    else if (!is_tail_d && bus.cs_full)
      chk_trap_d = TRAP_CALL_STACK_EXHAUSTED;
    else
      chk_trap_d = TRAP_NONE;

    // Enables are combinational so push/pop land in the CHECK/POP cycle
    // itself; gating with rst suppresses them in the reset cycle.
    push_d = !rst && (state_q == S_CHECK) && (chk_trap_d == TRAP_NONE);
    pop_d  = (!rst && (state_q == S_POP) && !bus.cs_empty) ||
             (push_d && is_tail_d && !bus.cs_empty);

    // A tail call replacing the top frame inherits the caller's return
    // context so the eventual RETURN skips straight past the tail caller.
    push_data_d.return_pc   = ret_pc_q;
    push_data_d.locals_base = FRAME_SP_W'(locals_base_q);
    if (is_tail_d && !bus.cs_empty) begin
      push_data_d.return_pc   = bus.cs_pop_data.return_pc;
      push_data_d.locals_base = bus.cs_pop_data.locals_base;
    end
    push_data_d.stack_base = FRAME_SP_W'(nb_d[SP_W-1:0]);
    push_data_d.func_idx   = func_idx_q;

    ret_sp_d = SP_W'(bus.cs_pop_data.stack_base) + SP_W'(result_count_q);
  end

  assign w_unused_bits = ^bus.cs_pop_data.func_idx;

  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.ft_rd_en         = ft_rd_en_q;
  assign bus.ft_rd_addr       = ft_rd_addr_q;
  assign bus.cs_push_en       = push_d;
  assign bus.cs_pop_en        = pop_d;
  assign bus.cs_push_data     = push_d ? push_data_d : '0;
  assign bus.done_valid       = done_valid_q;
  assign bus.done_pc          = done_pc_q;
  assign bus.done_locals_base = done_lb_q;
  assign bus.done_sp          = done_sp_q;
  assign bus.done_exit        = done_exit_q;
  assign bus.done_trap        = done_trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      func_idx_q     <= '0;
      ret_pc_q       <= '0;
      locals_base_q  <= '0;
      sp_q           <= '0;
      result_count_q <= '0;
      ft_rd_en_q     <= 1'b0;
      ft_rd_addr_q   <= '0;
      done_valid_q   <= 1'b0;
      done_pc_q      <= '0;
      done_lb_q      <= '0;
      done_sp_q      <= '0;
      done_exit_q    <= 1'b0;
      done_trap_q    <= TRAP_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q           <= bus.req_op;
            func_idx_q     <= bus.req_func_idx;
            ret_pc_q       <= bus.req_return_pc;
            locals_base_q  <= bus.req_locals_base;
            sp_q           <= bus.req_sp;
            result_count_q <= bus.req_result_count;
            done_pc_q      <= '0;
            done_lb_q      <= '0;
            done_sp_q      <= '0;
            done_exit_q    <= 1'b0;
            done_trap_q    <= TRAP_NONE;
            if (bus.req_op == OP_CALL || (TAIL_EN && bus.req_op == OP_TAIL)) begin
              if (32'(bus.req_func_idx) >= 32'(FUNC_COUNT)) begin
                done_trap_q  <= TRAP_UNDEFINED_ELEMENT;
                done_valid_q <= 1'b1;
                state_q      <= S_DONE;
              end else begin
                ft_rd_en_q   <= 1'b1;
                ft_rd_addr_q <= bus.req_func_idx;
                state_q      <= S_FETCH;
              end
            end else if (bus.req_op == OP_RETURN) begin
              state_q <= S_POP;
            end else begin
              done_trap_q  <= TRAP_UNREACHABLE;
              done_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end
          end
        end

        S_FETCH: begin
          ft_rd_en_q <= 1'b0;
          state_q    <= S_CHECK;
        end

        S_CHECK: begin
          done_trap_q <= chk_trap_d;
          if (chk_trap_d == TRAP_NONE) begin
            done_pc_q <= bus.ft_entry_pc;
            done_lb_q <= nb_d[SP_W-1:0];
            done_sp_q <= nsp_d[SP_W-1:0];
          end
          done_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end

        S_POP: begin
          if (bus.cs_empty) begin
            done_exit_q <= 1'b1;
          end else begin
            done_pc_q <= bus.cs_pop_data.return_pc;
            done_lb_q <= SP_W'(bus.cs_pop_data.locals_base);
            done_sp_q <= ret_sp_d;
          end
          done_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end

        S_DONE: begin
          if (bus.done_ready) begin
            done_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wasm_call_ctrl.sv
//------------------------------------------------------------------------------
// tb_wasm_call_ctrl
//   Directed testbench for wasm_call_ctrl. A one-cycle-latency function
//   table model answers ft_rd_en; call-stack status/data are driven directly.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wasm_call_ctrl;
  import wasm_call_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] tbl_pc;
  logic [7:0]  tbl_params;
  logic [15:0] tbl_locals;

  wasm_call_ctrl_if #(.SP_W(16)) bus ();

  wasm_call_ctrl #(.FUNC_COUNT(256), .SP_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function-table model: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.ft_rd_en) begin
      bus.ft_entry_pc   <= tbl_pc;
      bus.ft_num_params <= tbl_params;
      bus.ft_num_locals <= tbl_locals;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid        = 1'b0;
    bus.req_op           = 2'd0;
    bus.req_func_idx     = 16'd0;
    bus.req_return_pc    = 32'd0;
    bus.req_locals_base  = 16'd0;
    bus.req_sp           = 16'd0;
    bus.req_result_count = 8'd0;
    bus.cs_pop_data      = '0;
    bus.cs_full          = 1'b0;
    bus.cs_empty         = 1'b0;
    bus.done_ready       = 1'b0;
  endtask

  // Presents one request; returns after the accept edge (cycle 0) + #1.
  task automatic issue(input logic [1:0] op, input logic [15:0] idx,
                       input logic [31:0] rpc, input logic [15:0] lb,
                       input logic [15:0] sp, input logic [7:0] rc);
    bus.req_valid        = 1'b1;
    bus.req_op           = op;
    bus.req_func_idx     = idx;
    bus.req_return_pc    = rpc;
    bus.req_locals_base  = lb;
    bus.req_sp           = sp;
    bus.req_result_count = rc;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_done();
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    n_tests++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_valid got %b want 0", bus.done_valid); end
    n_tests++; if (bus.ft_rd_en !== 1'b0 || bus.cs_push_en !== 1'b0 || bus.cs_pop_en !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got rd=%b push=%b pop=%b want 0", bus.ft_rd_en, bus.cs_push_en, bus.cs_pop_en); end
    n_tests++; if (bus.done_trap !== TRAP_NONE || bus.done_exit !== 1'b0 || bus.done_pc !== 32'd0) begin n_fail++; $display("FAIL reset_done_fields got trap=%0d exit=%b pc=%h want 0", bus.done_trap, bus.done_exit, bus.done_pc); end
  endtask

  task automatic test_call();
    tbl_pc = 32'h100; tbl_params = 8'd2; tbl_locals = 16'd3;
    issue(OP_CALL, 16'd5, 32'h0000_0abc, 16'd7, 16'd20, 8'd0);
    n_tests++; if (bus.ft_rd_en !== 1'b1 || bus.ft_rd_addr !== 16'd5) begin n_fail++; $display("FAIL call_c1_fetch got en=%b addr=%0d want 1/5", bus.ft_rd_en, bus.ft_rd_addr); end
    n_tests++; if (bus.req_ready !== 1'b0 || bus.cs_push_en !== 1'b0) begin n_fail++; $display("FAIL call_c1_state got ready=%b push=%b want 0/0", bus.req_ready, bus.cs_push_en); end
    tick();
    n_tests++; if (bus.cs_push_en !== 1'b1 || bus.cs_pop_en !== 1'b0) begin n_fail++; $display("FAIL call_c2_push got push=%b pop=%b want 1/0", bus.cs_push_en, bus.cs_pop_en); end
    n_tests++; if (bus.cs_push_data.return_pc !== 32'h0abc || bus.cs_push_data.locals_base !== 16'd7 || bus.cs_push_data.stack_base !== 16'd18 || bus.cs_push_data.func_idx !== 16'd5) begin n_fail++; $display("FAIL call_push_data got rpc=%h lb=%0d sb=%0d fi=%0d want abc/7/18/5", bus.cs_push_data.return_pc, bus.cs_push_data.locals_base, bus.cs_push_data.stack_base, bus.cs_push_data.func_idx); end
    n_tests++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL call_c2_done got %b want 0", bus.done_valid); end
    tick();
    n_tests++; if (bus.done_valid !== 1'b1 || bus.cs_push_en !== 1'b0) begin n_fail++; $display("FAIL call_c3_done got valid=%b push=%b want 1/0", bus.done_valid, bus.cs_push_en); end
    n_tests++; if (bus.done_pc !== 32'h100 || bus.done_locals_base !== 16'd18 || bus.done_sp !== 16'd23 || bus.done_trap !== TRAP_NONE) begin n_fail++; $display("FAIL call_result got pc=%h lb=%0d sp=%0d trap=%0d want 100/18/23/0", bus.done_pc, bus.done_locals_base, bus.done_sp, bus.done_trap); end
    finish_done();
    n_tests++; if (bus.done_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL call_release got valid=%b ready=%b want 0/1", bus.done_valid, bus.req_ready); end
  endtask

  task automatic test_call_traps();
    // Call stack full
    tbl_pc = 32'h200; tbl_params = 8'd0; tbl_locals = 16'd1;
    bus.cs_full = 1'b1;
    issue(OP_CALL, 16'd9, 32'h10, 16'd0, 16'd4, 8'd0);
    tick();
    n_tests++; if (bus.cs_push_en !== 1'b0) begin n_fail++; $display("FAIL full_push got %b want 0", bus.cs_push_en); end
    tick();
    n_tests++; if (bus.done_valid !== 1'b1 || bus.done_trap !== TRAP_CALL_STACK_EXHAUSTED) begin n_fail++; $display("FAIL full_trap got v=%b trap=%0d want 1/%0d", bus.done_valid, bus.done_trap, TRAP_CALL_STACK_EXHAUSTED); end
    finish_done();
    bus.cs_full = 1'b0;
    // Out-of-range index traps at cycle 1 with no table read
    issue(OP_CALL, 16'd300, 32'h10, 16'd0, 16'd4, 8'd0);
    n_tests++; if (bus.done_valid !== 1'b1 || bus.done_trap !== TRAP_UNDEFINED_ELEMENT || bus.ft_rd_en !== 1'b0) begin n_fail++; $display("FAIL badidx got v=%b trap=%0d rd=%b want 1/%0d/0", bus.done_valid, bus.done_trap, bus.ft_rd_en, TRAP_UNDEFINED_ELEMENT); end
    finish_done();
    // Underflow: sp 1, params 2
    tbl_params = 8'd2; tbl_locals = 16'd0;
    issue(OP_CALL, 16'd1, 32'h10, 16'd0, 16'd1, 8'd0);
    tick();
    n_tests++; if (bus.cs_push_en !== 1'b0) begin n_fail++; $display("FAIL uflow_push got %b want 0", bus.cs_push_en); end
    tick();
    n_tests++; if (bus.done_trap !== TRAP_STACK_UNDERFLOW) begin n_fail++; $display("FAIL uflow_trap got %0d want %0d", bus.done_trap, TRAP_STACK_UNDERFLOW); end
    finish_done();
    // Overflow: sp 0xFFF0, params 0, locals 0x20 (also cs_full: overflow wins)
    tbl_params = 8'd0; tbl_locals = 16'h20; bus.cs_full = 1'b1;
    issue(OP_CALL, 16'd2, 32'h10, 16'd0, 16'hFFF0, 8'd0);
    tick();
    n_tests++; if (bus.cs_push_en !== 1'b0) begin n_fail++; $display("FAIL oflow_push got %b want 0", bus.cs_push_en); end
    tick();
    n_tests++; if (bus.done_trap !== TRAP_STACK_OVERFLOW) begin n_fail++; $display("FAIL oflow_trap got %0d want %0d", bus.done_trap, TRAP_STACK_OVERFLOW); end
    finish_done();
    bus.cs_full = 1'b0;
    // Reserved op 3
    issue(2'd3, 16'd0, 32'h0, 16'd0, 16'd0, 8'd0);
    n_tests++; if (bus.done_valid !== 1'b1 || bus.done_trap !== TRAP_UNREACHABLE) begin n_fail++; $display("FAIL op3 got v=%b trap=%0d want 1/%0d", bus.done_valid, bus.done_trap, TRAP_UNREACHABLE); end
    finish_done();
  endtask

  task automatic test_return();
    bus.cs_empty    = 1'b0;
    bus.cs_pop_data = '{return_pc: 32'h44, locals_base: 16'd10, stack_base: 16'd12, func_idx: 16'd3};
    issue(OP_RETURN, 16'd0, 32'h0, 16'd0, 16'd50, 8'd1);
    n_tests++; if (bus.cs_pop_en !== 1'b1 || bus.cs_push_en !== 1'b0) begin n_fail++; $display("FAIL ret_c1 got pop=%b push=%b want 1/0", bus.cs_pop_en, bus.cs_push_en); end
    tick();
    n_tests++; if (bus.done_valid !== 1'b1 || bus.cs_pop_en !== 1'b0) begin n_fail++; $display("FAIL ret_c2 got v=%b pop=%b want 1/0", bus.done_valid, bus.cs_pop_en); end
    n_tests++; if (bus.done_pc !== 32'h44 || bus.done_locals_base !== 16'd10 || bus.done_sp !== 16'd13 || bus.done_exit !== 1'b0) begin n_fail++; $display("FAIL ret_result got pc=%h lb=%0d sp=%0d exit=%b want 44/10/13/0", bus.done_pc, bus.done_locals_base, bus.done_sp, bus.done_exit); end
    finish_done();
    bus.cs_empty = 1'b1;
    issue(OP_RETURN, 16'd0, 32'h0, 16'd0, 16'd0, 8'd2);
    n_tests++; if (bus.cs_pop_en !== 1'b0) begin n_fail++; $display("FAIL ret_empty_pop got %b want 0", bus.cs_pop_en); end
    tick();
    n_tests++; if (bus.done_valid !== 1'b1 || bus.done_exit !== 1'b1) begin n_fail++; $display("FAIL ret_empty_exit got v=%b exit=%b want 1/1", bus.done_valid, bus.done_exit); end
    finish_done();
    bus.cs_empty = 1'b0;
  endtask

  task automatic test_hold();
    tbl_pc = 32'h300; tbl_params = 8'd1; tbl_locals = 16'd4;
    issue(OP_CALL, 16'd8, 32'h20, 16'd2, 16'd10, 8'd0);
    tick(); tick();
    bus.req_valid = 1'b1; bus.req_op = OP_RETURN;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (bus.done_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.done_pc !== 32'h300 || bus.done_locals_base !== 16'd9 || bus.done_sp !== 16'd14) begin n_fail++; $display("FAIL hold_%0d got v=%b rdy=%b pc=%h lb=%0d sp=%0d want 1/0/300/9/14", i, bus.done_valid, bus.req_ready, bus.done_pc, bus.done_locals_base, bus.done_sp); end
      tick();
    end
    n_tests++; if (bus.cs_pop_en !== 1'b0) begin n_fail++; $display("FAIL hold_no_accept got pop=%b want 0", bus.cs_pop_en); end
    bus.req_valid = 1'b0;
    finish_done();
  endtask

  task automatic test_reset_mid();
    tbl_pc = 32'h400; tbl_params = 8'd0; tbl_locals = 16'd1;
    issue(OP_CALL, 16'd4, 32'h30, 16'd0, 16'd8, 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (bus.req_ready !== 1'b1 || bus.cs_push_en !== 1'b0 || bus.ft_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got rdy=%b push=%b rd=%b want 1/0/0", bus.req_ready, bus.cs_push_en, bus.ft_rd_en); end
    tick();
    n_tests++; if (bus.cs_push_en !== 1'b0 || bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got push=%b v=%b want 0/0", bus.cs_push_en, bus.done_valid); end
  endtask

  task automatic test_tail();
    tbl_pc = 32'h500; tbl_params = 8'd1; tbl_locals = 16'd2;
    bus.cs_empty    = 1'b0;
    bus.cs_pop_data = '{return_pc: 32'h777, locals_base: 16'd9, stack_base: 16'd5, func_idx: 16'd1};
    issue(OP_TAIL, 16'd7, 32'h60, 16'd25, 16'd30, 8'd0);
`ifdef WASM_CALL_TAIL_EN
    n_tests++; if (bus.ft_rd_en !== 1'b1) begin n_fail++; $display("FAIL tail_fetch got %b want 1", bus.ft_rd_en); end
    tick();
    n_tests++; if (bus.cs_push_en !== 1'b1 || bus.cs_pop_en !== 1'b1) begin n_fail++; $display("FAIL tail_pushpop got push=%b pop=%b want 1/1", bus.cs_push_en, bus.cs_pop_en); end
    n_tests++; if (bus.cs_push_data.return_pc !== 32'h777 || bus.cs_push_data.locals_base !== 16'd9 || bus.cs_push_data.stack_base !== 16'd29 || bus.cs_push_data.func_idx !== 16'd7) begin n_fail++; $display("FAIL tail_data got rpc=%h lb=%0d sb=%0d fi=%0d want 777/9/29/7", bus.cs_push_data.return_pc, bus.cs_push_data.locals_base, bus.cs_push_data.stack_base, bus.cs_push_data.func_idx); end
    tick();
    n_tests++; if (bus.done_pc !== 32'h500 || bus.done_locals_base !== 16'd29 || bus.done_sp !== 16'd32) begin n_fail++; $display("FAIL tail_result got pc=%h lb=%0d sp=%0d want 500/29/32", bus.done_pc, bus.done_locals_base, bus.done_sp); end
`else
    n_tests++; if (bus.done_valid !== 1'b1 || bus.done_trap !== TRAP_UNREACHABLE || bus.ft_rd_en !== 1'b0) begin n_fail++; $display("FAIL tail_disabled got v=%b trap=%0d rd=%b want 1/%0d/0", bus.done_valid, bus.done_trap, bus.ft_rd_en, TRAP_UNREACHABLE); end
`endif
    finish_done();
  endtask

  task automatic test_back_to_back();
    bus.cs_empty    = 1'b0;
    bus.cs_pop_data = '{return_pc: 32'h90, locals_base: 16'd1, stack_base: 16'd2, func_idx: 16'd0};
    bus.done_ready  = 1'b1;
    issue(OP_RETURN, 16'd0, 32'h0, 16'd0, 16'd0, 8'd0);
    bus.req_valid = 1'b1;
    tick();
    n_tests++; if (bus.done_valid !== 1'b1 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done got v=%b rdy=%b want 1/0", bus.done_valid, bus.req_ready); end
    tick();
    n_tests++; if (bus.req_ready !== 1'b1 || bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got rdy=%b v=%b want 1/0", bus.req_ready, bus.done_valid); end
    tick();
    bus.req_valid = 1'b0;
    n_tests++; if (bus.cs_pop_en !== 1'b1) begin n_fail++; $display("FAIL b2b_second_pop got %b want 1", bus.cs_pop_en); end
    tick();
    tick();
    bus.done_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tbl_pc = '0; tbl_params = '0; tbl_locals = '0;
    test_reset();
    test_call();
    test_call_traps();
    test_return();
    test_hold();
    test_reset_mid();
    test_tail();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
